fifo_stage: RTL and testbench

FIFO_STAGE -- requirements
Module: fifo_stage

---
 rtl/fifo_stage.sv | 80 ++++++++
 tb/tb_fifo_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stage.sv
// fifo_stage: single-datum 4-phase handshake pipeline stage (IDLE/ACKIN/HOLD/OFFER/RELEASE).
// Optional transfer counter port xfer_cnt enabled by macro FIFO_STAGE_CNT_EN. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module fifo_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             rr,
  output logic             ar,
  output logic [WIDTH-1:0] dout,
  output logic             rw,
  input  logic             aw
`ifdef FIFO_STAGE_CNT_EN
  ,
  output logic [7:0]       xfer_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACKIN   = 3'd1,
    HOLD    = 3'd2,
    OFFER   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   capture;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (rr) begin
          state_nxt = ACKIN;
          capture   = 1'b1;
        end
      end
      ACKIN:   if (!rr) state_nxt = HOLD;
      HOLD:    if (!aw) state_nxt = OFFER;
      OFFER:   if (aw)  state_nxt = RELEASE;
      RELEASE: if (!aw) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they are true flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ar    <= 1'b0;
      rw    <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_nxt;
      ar    <= (state_nxt == ACKIN);
      rw    <= (state_nxt == OFFER);
      if (capture) dout <= din;
    end
  end

`ifdef FIFO_STAGE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_cnt <= 8'd0;
    end else if (state == OFFER && aw) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_stage.sv
// tb_fifo_stage: vector table, directed corner sequences and a random run against a phase model.
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rr = 1'b0;
  logic       aw = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ar;
  logic       rw;
  logic [7:0] dout;
`ifdef FIFO_STAGE_CNT_EN
  logic [7:0] xfer_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fifo_stage #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .din     (din),
    .rr      (rr),
    .ar      (ar),
    .dout    (dout),
    .rw      (rw),
    .aw      (aw)
`ifdef FIFO_STAGE_CNT_EN
    ,
    .xfer_cnt(xfer_cnt)
`endif
  );

  typedef struct {
    logic       rr;
    logic       aw;
    logic [7:0] din;
    logic       ar;
    logic       rw;
    logic [7:0] dout;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string name, input logic [7:0] exp);
`ifdef FIFO_STAGE_CNT_EN
    check(name, {24'd0, xfer_cnt}, {24'd0, exp});
`else
    if (exp === 8'hxx) $display("note: %s", name);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rr    = 1'b0;
    aw    = 1'b0;
    din   = 8'h00;
    repeat (3) step();
    check("reset_ar", {31'd0, ar}, 32'd0);
    check("reset_rw", {31'd0, rw}, 32'd0);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check_cnt("reset_cnt", 8'd0);
    reset = 1'b1;
  endtask

  // Upstream raises rr when idle, drops it on ar; downstream mirrors rw onto aw.
  task automatic run_xfers(input int n, input logic [7:0] base);
    logic [7:0] q[$];
    int sent = 0;
    int recv = 0;
    int cyc = 0;
    int last_cap = -1;
    rr  = 1'b1;
    din = base;
    aw  = 1'b0;
    while (recv < n && cyc < n * 8 + 50) begin
      step();
      cyc++;
      check("ar_rw_excl", {31'd0, ar & rw}, 32'd0);
      if (ar) begin
        if (last_cap >= 0) check("round_trip", cyc - last_cap, 32'd5);
        last_cap = cyc;
        q.push_back(din);
        sent++;
        rr = 1'b0;
      end else if (!rr && sent < n) begin
        din = base + sent[7:0];
        rr  = 1'b1;
      end
      if (rw && !aw) begin
        if (q.size() == 0) begin
          check("xfer_spurious", 32'd1, 32'd0);
        end else begin
          check("xfer_dout", {24'd0, dout}, {24'd0, q.pop_front()});
        end
        recv++;
      end
      aw = rw;
    end
    check("xfer_count", recv, n);
    step();
    aw = 1'b0;
    step();
    check("xfer_end_ar", {31'd0, ar}, 32'd0);
    check("xfer_end_rw", {31'd0, rw}, 32'd0);
  endtask

  initial begin
    int         ph;
    logic [7:0] m_dout;
    logic [7:0] m_cnt;
    logic [4:0] go;

    //            rr aw din    ar rw dout   cnt
    tbl[0]  = '{1'b1, 1'b0, 8'h56, 1'b1, 1'b0, 8'h56, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 8'h56, 1'b1, 1'b0, 8'h56, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h56, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 8'h56, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 8'h56, 8'd0};
    tbl[5]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[6]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 8'hAA, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[9]  = '{1'b1, 1'b0, 8'h56, 1'b1, 1'b0, 8'h56, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[12] = '{1'b0, 1'b1, 8'h56, 1'b0, 1'b0, 8'h56, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 8'h56, 1'b0, 1'b1, 8'h56, 8'd1};
    tbl[14] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h56, 8'd1};
    tbl[15] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h56, 8'd2};
    tbl[16] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h56, 8'd2};
    tbl[17] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'd2};
    tbl[18] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'd2};
    tbl[19] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 8'd2};
    tbl[20] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'd3};
    tbl[21] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'd3};

    do_reset();

    for (int i = 0; i < 22; i++) begin
      rr  = tbl[i].rr;
      aw  = tbl[i].aw;
      din = tbl[i].din;
      step();
      check($sformatf("vec%0d_ar", i), {31'd0, ar}, {31'd0, tbl[i].ar});
      check($sformatf("vec%0d_rw", i), {31'd0, rw}, {31'd0, tbl[i].rw});
      check($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, tbl[i].dout});
      check_cnt($sformatf("vec%0d_cnt", i), tbl[i].cnt);
    end

    // Back-to-back stream 0x56..0xB9 from a fresh reset.
    do_reset();
    run_xfers(100, 8'h56);
    check_cnt("cnt_after_100", 8'd100);

    // Asynchronous reset while offering: outputs clear before any clock edge.
    rr = 1'b1; din = 8'h56; step();
    rr = 1'b0; step();
    step();
    check("pre_reset_rw", {31'd0, rw}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rw", {31'd0, rw}, 32'd0);
    check("async_ar", {31'd0, ar}, 32'd0);
    check("async_dout", {24'd0, dout}, 32'd0);
    check_cnt("async_cnt", 8'd0);
    step();
    step();
    reset = 1'b1;
    step();
    step();
    check("post_reset_idle_ar", {31'd0, ar}, 32'd0);
    check("post_reset_idle_rw", {31'd0, rw}, 32'd0);
    rr = 1'b1; din = 8'h33; step();
    check("post_reset_capture_ar", {31'd0, ar}, 32'd1);
    check("post_reset_capture_dout", {24'd0, dout}, 32'h33);
    rr = 1'b0; step();
    step();
    aw = 1'b1; step();
    aw = 1'b0; step();

    // Random inputs against a phase-counting model of the handshake ring.
    do_reset();
    ph     = 0;
    m_dout = 8'h00;
    m_cnt  = 8'd0;
    for (int c = 0; c < 600; c++) begin
      rr  = ($urandom_range(0, 2) != 0);
      aw  = ($urandom_range(0, 2) == 0) ? ~aw : aw;
      din = 8'($urandom);
      go  = {!aw, aw, !aw, !rr, rr};
      if (go[ph]) begin
        if (ph == 0) m_dout = din;
        if (ph == 3) m_cnt = m_cnt + 8'd1;
        ph = (ph + 1) % 5;
      end
      step();
      check("rnd_ar", {31'd0, ar}, {31'd0, ph == 1});
      check("rnd_rw", {31'd0, rw}, {31'd0, ph == 3});
      check("rnd_dout", {24'd0, dout}, {24'd0, m_dout});
      check_cnt("rnd_cnt", m_cnt);
    end

`ifdef FIFO_STAGE_CNT_EN
    do_reset();
    run_xfers(255, 8'h00);
    check_cnt("cnt_255", 8'd255);
    run_xfers(1, 8'hC3);
    check_cnt("cnt_wrap", 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
